// File: rtl/vc_trace_pkg.sv
// vc_trace_pkg
//   Types and helpers shared by the vcache trace monitors (vc_fwd_trace,
//   vc_rev_trace). Coordinates are zero-extended to cord_width_max_lp bits
//   so one entry layout serves every link configuration.
package vc_trace_pkg;

    localparam int cord_width_max_lp = 16;

    typedef struct packed {
        logic [31:0]                  ctr;
        logic [cord_width_max_lp-1:0] src_x;
        logic [cord_width_max_lp-1:0] src_y;
        logic [cord_width_max_lp-1:0] x_cord;
        logic [cord_width_max_lp-1:0] y_cord;
        logic                         in_window;
    } vc_trace_entry_s;

    localparam int vc_trace_entry_width_lp = $bits(vc_trace_entry_s);

    // True when (x,y) lies in [nx,2*nx) x [ny,2*ny). The comparison is done
    // one bit wider so that 2*n cannot wrap.
    function automatic logic in_tile_window(
        input logic [cord_width_max_lp-1:0] x,
        input logic [cord_width_max_lp-1:0] y,
        input logic [cord_width_max_lp-1:0] nx,
        input logic [cord_width_max_lp-1:0] ny
    );
        return ({1'b0, x} >= {1'b0, nx}) && ({1'b0, x} < {nx, 1'b0})
            && ({1'b0, y} >= {1'b0, ny}) && ({1'b0, y} < {ny, 1'b0});
    endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small
//   Small in-order FIFO with one write and one read port.
//   clk_i, reset_i : clock, synchronous active-high reset (clears pointers)
//   v_i, data_i    : write request; caller only asserts v_i when ready_o
//   ready_o        : space available, or the head is being popped this cycle
//   v_o, data_o    : head entry valid / head entry (combinational read)
//   yumi_i         : pop the head; caller only asserts it when v_o
module bsg_fifo_1r1w_small #(
    parameter int els_p   = 16,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = $clog2(els_p);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ptr_width_lp:0] wptr_q, wptr_d;
    logic [ptr_width_lp:0] rptr_q, rptr_d;
    logic [width_p-1:0]    mem_q [els_p];

    logic empty, full;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0])
                  && (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp]);
    // A write into a full queue is fine when the head leaves in the same cycle:
    // the head slot is read before the edge and overwritten at it.
    assign ready_o = ~full | yumi_i;
    assign v_o     = ~empty;
    // Head must be visible in the pop cycle, so the read is asynchronous.
    assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];

    assign wptr_d = wptr_q + (ptr_width_lp+1)'(v_i);
    assign rptr_d = rptr_q + (ptr_width_lp+1)'(yumi_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i && !reset_i) begin
            mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vc_fwd_trace.sv
// vc_fwd_trace
//   Forward-side latency monitor for a manycore-link-to-vcache adapter.
//   Each accepted request is timestamped and queued in order; each return
//   handshake pops the oldest entry and reports its round-trip latency.
//   Inputs : clk_i, reset_i, packet_li/_v_li/_yumi_li (request side),
//            return_packet_li/_v_li/_ready_lo (return side), global_ctr_i
//   Outputs: outstanding_o, max_latency_o, sticky overflow_o / underflow_o /
//            mismatch_o (all registered)
//   Trace  : trace_v_o pulses combinationally in the pop cycle of an
//            in-window entry; trace_*_o carry the dpi_vc_fwd_trace arguments
//            so the bind wrapper can issue the call at that same posedge.
//   Packet layout (LSB first): x_cord, y_cord, src_x, src_y, data, addr.
//   Return layout (LSB first): x_cord, y_cord, data.
module vc_fwd_trace
    import vc_trace_pkg::*;
#(
    parameter int link_addr_width_p = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 7,
    parameter int y_cord_width_p    = 7,
    parameter int num_tiles_x_p     = 4,
    parameter int num_tiles_y_p     = 8,
    parameter int els_p             = 16,
    localparam int packet_width_lp  = link_addr_width_p + data_width_p
                                    + 2*(x_cord_width_p + y_cord_width_p),
    localparam int return_width_lp  = data_width_p + x_cord_width_p + y_cord_width_p,
    localparam int count_width_lp   = $clog2(els_p+1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [packet_width_lp-1:0] packet_li,
    input  logic                       packet_v_li,
    input  logic                       packet_yumi_li,
    input  logic [return_width_lp-1:0] return_packet_li,
    input  logic                       return_packet_v_li,
    input  logic                       return_packet_ready_lo,
    input  logic [31:0]                global_ctr_i,
    output logic [count_width_lp-1:0]  outstanding_o,
    output logic [31:0]                max_latency_o,
    output logic                       overflow_o,
    output logic                       underflow_o,
    output logic                       mismatch_o,
    output logic                       trace_v_o,
    output logic [31:0]                trace_ctr_o,
    output logic [x_cord_width_p-1:0]  trace_src_x_o,
    output logic [y_cord_width_p-1:0]  trace_src_y_o,
    output logic [x_cord_width_p-1:0]  trace_x_cord_o,
    output logic [y_cord_width_p-1:0]  trace_y_cord_o,
    output logic [31:0]                trace_latency_o
);

    localparam int xw = x_cord_width_p;
    localparam int yw = y_cord_width_p;

    // Packet casts
    logic [xw-1:0] req_x, req_src_x, ret_x;
    logic [yw-1:0] req_y, req_src_y, ret_y;

    assign req_x     = packet_li[0 +: xw];
    assign req_y     = packet_li[xw +: yw];
    assign req_src_x = packet_li[xw+yw +: xw];
    assign req_src_y = packet_li[2*xw+yw +: yw];
    assign ret_x     = return_packet_li[0 +: xw];
    assign ret_y     = return_packet_li[xw +: yw];

    vc_trace_entry_s wr_entry, rd_entry;
    logic [vc_trace_entry_width_lp-1:0] rd_entry_raw;
    logic fifo_ready, fifo_v;

    always_comb begin
        wr_entry.ctr       = global_ctr_i;
        wr_entry.src_x     = cord_width_max_lp'(req_src_x);
        wr_entry.src_y     = cord_width_max_lp'(req_src_y);
        wr_entry.x_cord    = cord_width_max_lp'(req_x);
        wr_entry.y_cord    = cord_width_max_lp'(req_y);
        wr_entry.in_window = in_tile_window(cord_width_max_lp'(req_src_x),
                                            cord_width_max_lp'(req_src_y),
                                            cord_width_max_lp'(num_tiles_x_p),
                                            cord_width_max_lp'(num_tiles_y_p));
    end

    assign rd_entry = vc_trace_entry_s'(rd_entry_raw);

    logic enq_hs, deq_hs, enq_fire, deq_fire;
    logic [31:0] latency;

    assign enq_hs   = packet_v_li & packet_yumi_li;
    assign deq_hs   = return_packet_v_li & return_packet_ready_lo;
    // fifo_v is registered state, so a same-cycle enqueue into an empty
    // queue never satisfies a return.
    assign deq_fire = deq_hs & fifo_v & ~reset_i;
    assign enq_fire = enq_hs & fifo_ready & ~reset_i;
    // Modulo-2^32 difference gives the right answer across counter wrap.
    assign latency  = global_ctr_i - rd_entry.ctr;

    bsg_fifo_1r1w_small #(
        .els_p   (els_p),
        .width_p (vc_trace_entry_width_lp)
    ) queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (enq_fire),
        .data_i  (wr_entry),
        .ready_o (fifo_ready),
        .v_o     (fifo_v),
        .data_o  (rd_entry_raw),
        .yumi_i  (deq_fire)
    );

    assign trace_v_o       = deq_fire & rd_entry.in_window;
    assign trace_ctr_o     = global_ctr_i;
    assign trace_src_x_o   = xw'(rd_entry.src_x);
    assign trace_src_y_o   = yw'(rd_entry.src_y);
    assign trace_x_cord_o  = xw'(rd_entry.x_cord);
    assign trace_y_cord_o  = yw'(rd_entry.y_cord);
    assign trace_latency_o = latency;

    logic [count_width_lp-1:0] outstanding_q;
    logic [31:0]               max_latency_q;
    logic                      overflow_q, underflow_q, mismatch_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding_q <= '0;
            max_latency_q <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            mismatch_q    <= 1'b0;
        end else begin
            if (enq_fire && !deq_fire) begin
                outstanding_q <= outstanding_q + count_width_lp'(1);
            end else if (deq_fire && !enq_fire) begin
                outstanding_q <= outstanding_q - count_width_lp'(1);
            end
            if (enq_hs && !fifo_ready) begin
                overflow_q <= 1'b1;
            end
            if (deq_hs && !fifo_v) begin
                underflow_q <= 1'b1;
            end
            if (deq_fire && ((cord_width_max_lp'(ret_x) != rd_entry.src_x)
                          || (cord_width_max_lp'(ret_y) != rd_entry.src_y))) begin
                mismatch_q <= 1'b1;
            end
            if (trace_v_o && (latency > max_latency_q)) begin
                max_latency_q <= latency;
            end
        end
    end

    assign outstanding_o = outstanding_q;
    assign max_latency_o = max_latency_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
    assign mismatch_o    = mismatch_q;

endmodule

// File: tb/tb_vc_fwd_trace.sv
module tb_vc_fwd_trace;

    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int XW  = 7;
    localparam int YW  = 7;
    localparam int NX  = 4;
    localparam int NY  = 8;
    localparam int ELS = 16;
    localparam int PW  = AW + DW + 2*(XW+YW);
    localparam int RW  = DW + XW + YW;
    localparam int CW  = $clog2(ELS+1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic [PW-1:0] packet_li;
    logic          packet_v_li, packet_yumi_li;
    logic [RW-1:0] return_packet_li;
    logic          return_packet_v_li, return_packet_ready_lo;
    logic [31:0]   global_ctr_i;
    logic [CW-1:0] outstanding_o;
    logic [31:0]   max_latency_o;
    logic          overflow_o, underflow_o, mismatch_o;
    logic          trace_v_o;
    logic [31:0]   trace_ctr_o, trace_latency_o;
    logic [XW-1:0] trace_src_x_o, trace_x_cord_o;
    logic [YW-1:0] trace_src_y_o, trace_y_cord_o;

    always #5 clk = ~clk;

    vc_fwd_trace #(
        .link_addr_width_p (AW),
        .data_width_p      (DW),
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .num_tiles_x_p     (NX),
        .num_tiles_y_p     (NY),
        .els_p             (ELS)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (reset_i),
        .packet_li              (packet_li),
        .packet_v_li            (packet_v_li),
        .packet_yumi_li         (packet_yumi_li),
        .return_packet_li       (return_packet_li),
        .return_packet_v_li     (return_packet_v_li),
        .return_packet_ready_lo (return_packet_ready_lo),
        .global_ctr_i           (global_ctr_i),
        .outstanding_o          (outstanding_o),
        .max_latency_o          (max_latency_o),
        .overflow_o             (overflow_o),
        .underflow_o            (underflow_o),
        .mismatch_o             (mismatch_o),
        .trace_v_o              (trace_v_o),
        .trace_ctr_o            (trace_ctr_o),
        .trace_src_x_o          (trace_src_x_o),
        .trace_src_y_o          (trace_src_y_o),
        .trace_x_cord_o         (trace_x_cord_o),
        .trace_y_cord_o         (trace_y_cord_o),
        .trace_latency_o        (trace_latency_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference model: an ordered list of outstanding requests plus flags.
    typedef struct {
        logic [31:0] ctr;
        int          sx, sy, dx, dy;
        bit          inwin;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_max;
    bit          m_ovf, m_unf, m_mis;
    logic [31:0] gctr;
    int          txn = 0;

    function automatic bit win(input int x, input int y);
        return (x >= NX) && (x < 2*NX) && (y >= NY) && (y < 2*NY);
    endfunction

    // One clock cycle. req/ret mean a full handshake on that side; when they
    // are clear, the side shows at most one half of the handshake at random.
    task automatic step(input bit rst, input bit req, input int sx, input int sy,
                        input bit ret, input int rx, input int ry);
        int          dx, dy, n, r;
        bit          exp_tv, popped;
        logic [31:0] lat;
        ent_t        e;
        dx = $urandom_range(0, 15);
        dy = $urandom_range(0, 20);
        reset_i = rst;
        if (req) begin
            packet_v_li = 1'b1; packet_yumi_li = 1'b1;
        end else begin
            r = $urandom_range(0, 2);
            packet_v_li = (r == 1); packet_yumi_li = (r == 2);
        end
        if (ret) begin
            return_packet_v_li = 1'b1; return_packet_ready_lo = 1'b1;
        end else begin
            r = $urandom_range(0, 2);
            return_packet_v_li = (r == 1); return_packet_ready_lo = (r == 2);
        end
        packet_li = {AW'($urandom), DW'($urandom), YW'(sy), XW'(sx), YW'(dy), XW'(dx)};
        return_packet_li = {DW'($urandom), YW'(ry), XW'(rx)};
        global_ctr_i = gctr;
        #3;
        exp_tv = !rst && ret && (q.size() > 0) && q[0].inwin;
        check_val("trace_v", 32'(trace_v_o), 32'(exp_tv));
        if (exp_tv) begin
            check_val("trace_latency", trace_latency_o, gctr - q[0].ctr);
            check_val("trace_ctr", trace_ctr_o, gctr);
            check_val("trace_src_x", 32'(trace_src_x_o), 32'(q[0].sx));
            check_val("trace_src_y", 32'(trace_src_y_o), 32'(q[0].sy));
            check_val("trace_x_cord", 32'(trace_x_cord_o), 32'(q[0].dx));
            check_val("trace_y_cord", 32'(trace_y_cord_o), 32'(q[0].dy));
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_max = 0; m_ovf = 0; m_unf = 0; m_mis = 0;
        end else begin
            n = q.size();
            popped = 0;
            if (ret) begin
                if (n == 0) begin
                    m_unf = 1;
                end else begin
                    e = q.pop_front();
                    popped = 1;
                    lat = gctr - e.ctr;
                    if (rx != e.sx || ry != e.sy) m_mis = 1;
                    if (e.inwin && lat > m_max) m_max = lat;
                end
            end
            if (req) begin
                if (n == ELS && !popped) begin
                    m_ovf = 1;
                end else begin
                    e.ctr = gctr; e.sx = sx; e.sy = sy; e.dx = dx; e.dy = dy;
                    e.inwin = win(sx, sy);
                    q.push_back(e);
                end
            end
        end
        #1;
        check_val("outstanding", 32'(outstanding_o), 32'(q.size()));
        check_val("max_latency", max_latency_o, m_max);
        check_val("overflow", 32'(overflow_o), 32'(m_ovf));
        check_val("underflow", 32'(underflow_o), 32'(m_unf));
        check_val("mismatch", 32'(mismatch_o), 32'(m_mis));
        $display("txn %0d rst=%0b req=%0b ret=%0b ctr=%0d out=%0d max=%0d ovf=%0b unf=%0b mis=%0b",
                 txn, rst, req, ret, gctr, outstanding_o, max_latency_o,
                 overflow_o, underflow_o, mismatch_o);
        txn++;
        gctr = gctr + 1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int sx, sy, rx, ry;
        bit req, ret;
        gctr = 0;
        reset_i = 1'b1;
        packet_v_li = 0; packet_yumi_li = 0;
        return_packet_v_li = 0; return_packet_ready_lo = 0;
        packet_li = '0; return_packet_li = '0; global_ctr_i = '0;

        do_reset();
        do_reset();

        // Single in-window request, latency 37
        gctr = 100; step(0, 1, 4, 8, 0, 0, 0);
        idle();
        gctr = 137; step(0, 0, 0, 0, 1, 4, 8);

        // Three back-to-back requests, returns at 20, 25, 40
        do_reset();
        gctr = 10; step(0, 1, 5, 9, 0, 0, 0);
        step(0, 1, 6, 10, 0, 0, 0);
        step(0, 1, 7, 15, 0, 0, 0);
        gctr = 20; step(0, 0, 0, 0, 1, 5, 9);
        gctr = 25; step(0, 0, 0, 0, 1, 6, 10);
        gctr = 40; step(0, 0, 0, 0, 1, 7, 15);

        // Counter wrap
        do_reset();
        gctr = 32'hFFFF_FFF0; step(0, 1, 4, 8, 0, 0, 0);
        gctr = 32'h0000_0005; step(0, 0, 0, 0, 1, 4, 8);

        // Full queue: simultaneous req+ret is fine, a lone 17th overflows
        do_reset();
        for (int i = 0; i < ELS; i++) step(0, 1, 4 + (i % 4), 8 + (i % 8), 0, 0, 0);
        step(0, 1, 5, 9, 1, 4, 8);
        step(0, 1, 6, 9, 0, 0, 0);
        idle();

        // Underflow, then same-cycle enqueue into empty, then mismatch
        do_reset();
        step(0, 0, 0, 0, 1, 4, 8);
        step(0, 1, 4, 8, 1, 4, 8);
        step(0, 0, 0, 0, 1, 5, 8);

        // Out-of-window source
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        gctr = gctr + 500; step(0, 0, 0, 0, 1, 0, 0);

        // Reset with 5 outstanding, return pending during reset
        for (int i = 0; i < 5; i++) step(0, 1, 4, 8, 0, 0, 0);
        step(1, 0, 0, 0, 1, 4, 8);
        idle();

        // Randomized traffic, starting near counter wrap
        gctr = 32'hFFFF_FF00;
        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(0, 99) < 50);
            ret = ($urandom_range(0, 99) < 45);
            sx  = $urandom_range(0, 12);
            sy  = $urandom_range(0, 20);
            if (q.size() > 0 && $urandom_range(0, 9) != 0) begin
                rx = q[0].sx; ry = q[0].sy;
            end else begin
                rx = $urandom_range(0, 12); ry = $urandom_range(0, 20);
            end
            if ($urandom_range(0, 19) == 0) gctr = gctr + $urandom_range(0, 1000);
            step($urandom_range(0, 149) == 0, req, sx, sy, ret, rx, ry);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
